// File: rtl/vga_game_pkg.sv
// -----------------------------------------------------------------------------
// vga_game_pkg
// Shared types and constants for the VGA game peripheral blocks (player,
// missile, alien blocks).
//   PIX_W            : width of pixel row/column buses and position registers
//   H_RES / V_RES    : visible resolution
//   pix_t            : pixel coordinate type
//   missile_state_t  : missile state machine encoding
//   cnt_width()      : counter width helper that never returns zero
// -----------------------------------------------------------------------------
package vga_game_pkg;

    localparam int PIX_W = 12;
    localparam int H_RES = 640;
    localparam int V_RES = 480;

    typedef logic [PIX_W-1:0] pix_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        FLY    = 2'd2
    } missile_state_t;

    // A divide-by-1 counter still needs a one-bit register to exist.
    function automatic int cnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/player_ctrl_if.sv
// -----------------------------------------------------------------------------
// player_ctrl_if
// Bundles the scan position, button inputs, collision pulse and the sprite
// outputs of the player block.
//   master : scan/button/collision driver, consumer of the sprite outputs
//   slave  : the player block itself
// Signals:
//   pixel_row, pixel_column : current scan position
//   btn_left/right/fire     : debounced buttons
//   missile_hit             : one-cycle pulse, kills the missile
//   player_col              : left column of the cannon
//   missile_busy            : missile in flight (FSM not IDLE)
//   player_active/output    : cannon pixel enable / data (registered)
//   missile_active/output   : missile pixel enable / data (registered)
// -----------------------------------------------------------------------------
interface player_ctrl_if #(
    parameter int PIX_W = vga_game_pkg::PIX_W
);

    logic [PIX_W-1:0] pixel_row;
    logic [PIX_W-1:0] pixel_column;
    logic             btn_left;
    logic             btn_right;
    logic             btn_fire;
    logic             missile_hit;
    logic [PIX_W-1:0] player_col;
    logic             missile_busy;
    logic             player_active;
    logic [3:0]       player_output;
    logic             missile_active;
    logic [3:0]       missile_output;

    modport master (
        output pixel_row, pixel_column, btn_left, btn_right, btn_fire,
               missile_hit,
        input  player_col, missile_busy, player_active, player_output,
               missile_active, missile_output
    );

    modport slave (
        input  pixel_row, pixel_column, btn_left, btn_right, btn_fire,
               missile_hit,
        output player_col, missile_busy, player_active, player_output,
               missile_active, missile_output
    );

endinterface

// File: rtl/player_ctrl_motion_tick.sv
// -----------------------------------------------------------------------------
// motion_tick
// Free-running divider producing a one-cycle tick every DIV clocks. Shared by
// the player block and the alien blocks to pace sprite motion.
//   clk  : pixel clock
//   rst  : synchronous active-high reset (counter restarts at 0)
//   tick : high for the one cycle in which the counter holds DIV-1
// DIV = 1 yields a tick on every cycle.
// -----------------------------------------------------------------------------
module motion_tick #(
    parameter int DIV = 525000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    import vga_game_pkg::*;

    localparam int CW = cnt_width(DIV);
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t LAST = cnt_t'(DIV - 1);

    cnt_t cnt_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + cnt_t'(1);
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/player_ctrl.sv
// -----------------------------------------------------------------------------
// player_ctrl
// Player cannon and one-shot missile for the VGA game peripheral.
//   - Cannon column moves STEP pixels per motion tick while left or right is
//     held alone, clamped to [0, H_RES-SPRITE_W].
//   - Missile launches from the cannon centre, climbs MISSILE_STEP rows per
//     tick and dies at the top of the screen or on missile_hit.
//   - Cannon and missile pixel enable/data are registered (1-cycle latency
//     from the scan position).
// Ports:
//   clk  : pixel clock
//   rst  : synchronous active-high reset (also aborts a missile in flight)
//   bus  : player_ctrl_if.slave -- scan position, buttons, collision pulse,
//          player_col, missile_busy and the four pixel outputs
// Parameters: SPRITE_W must be >= 8 and even, SPRITE_H must be >= 5.
// Build option: define PLAYER_AUTOFIRE_EN to launch on a held fire button
// (level) instead of on its rising edge.
// -----------------------------------------------------------------------------
module player_ctrl #(
    parameter int         PIX_W        = vga_game_pkg::PIX_W,
    parameter int         H_RES        = vga_game_pkg::H_RES,
    parameter int         SPRITE_W     = 16,
    parameter int         SPRITE_H     = 10,
    parameter int         PLAYER_ROW   = 450,
    parameter int         STEP         = 4,
    parameter int         MOVE_DIV     = 525000,
    parameter int         MISSILE_H    = 6,
    parameter int         MISSILE_STEP = 8,
    parameter logic [3:0] PIX_VAL      = 4'hF
) (
    input  logic          clk,
    input  logic          rst,
    player_ctrl_if.slave  bus
);
    import vga_game_pkg::*;

    typedef logic [PIX_W-1:0] pos_t;
    // One extra bit so scan-minus-origin differences never wrap negative.
    typedef logic [PIX_W:0]   ext_t;

    localparam pos_t COL_RESET = pos_t'((H_RES - SPRITE_W) / 2);
    localparam ext_t COL_MAX   = ext_t'(H_RES - SPRITE_W);
    localparam ext_t STEP_X    = ext_t'(STEP);
    localparam pos_t HALF_W    = pos_t'(SPRITE_W / 2);
    localparam pos_t M_START   = pos_t'(PLAYER_ROW - MISSILE_H);
    localparam pos_t M_STEP    = pos_t'(MISSILE_STEP);
    localparam ext_t ROW_TOP   = ext_t'(PLAYER_ROW);
    localparam ext_t ROW_END   = ext_t'(PLAYER_ROW + SPRITE_H);
    localparam ext_t SW_X      = ext_t'(SPRITE_W);
    localparam ext_t HALF_X    = ext_t'(SPRITE_W / 2);
    localparam ext_t MH_X      = ext_t'(MISSILE_H);
    localparam ext_t R2_X      = ext_t'(2);
    localparam ext_t R3_X      = ext_t'(3);
    localparam ext_t C2_LO     = ext_t'(3);
    localparam ext_t C2_HI     = ext_t'(SPRITE_W - 3);
    localparam ext_t C3_LO     = ext_t'(2);
    localparam ext_t C3_HI     = ext_t'(SPRITE_W - 2);

    // ------------------------------------------------------------------
    // Motion pacing
    // ------------------------------------------------------------------
    logic tick;

    motion_tick #(
        .DIV (MOVE_DIV)
    ) u_motion_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // ------------------------------------------------------------------
    // Cannon position
    // ------------------------------------------------------------------
    pos_t player_col_q;
    pos_t player_col_d;
    ext_t pcol_x;
    ext_t col_sum;
    ext_t col_dif;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned (which would infer a latch).
        player_col_d = player_col_q;
        pcol_x       = {1'b0, player_col_q};
        col_sum      = pcol_x + STEP_X;
        col_dif      = pcol_x - STEP_X;
        if (tick) begin
            if (bus.btn_left && !bus.btn_right) begin
                player_col_d = (pcol_x >= STEP_X) ? col_dif[PIX_W-1:0] : '0;
            end else if (bus.btn_right && !bus.btn_left) begin
                player_col_d = (col_sum >= COL_MAX) ? COL_MAX[PIX_W-1:0]
                                                    : col_sum[PIX_W-1:0];
            end
        end
    end

    // NOTE: reset is synchronous, so it is just the highest-priority branch
    // inside the clocked process and rst is absent from the sensitivity list.
    always_ff @(posedge clk) begin
        if (rst) begin
            player_col_q <= COL_RESET;
        end else begin
            player_col_q <= player_col_d;
        end
    end

    // ------------------------------------------------------------------
    // Launch request
    // ------------------------------------------------------------------
    logic launch_req;

`ifdef PLAYER_AUTOFIRE_EN
    // Held button relaunches as soon as the FSM is back in IDLE.
    assign launch_req = bus.btn_fire;
`else
    logic btn_fire_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_fire_q <= 1'b0;
        end else begin
            btn_fire_q <= bus.btn_fire;
        end
    end

    // Only a fresh press launches; a press while busy is simply lost.
    assign launch_req = bus.btn_fire & ~btn_fire_q;
`endif

    // ------------------------------------------------------------------
    // Missile state machine
    // ------------------------------------------------------------------
    missile_state_t state_q;
    missile_state_t state_d;
    pos_t           m_col_q;
    pos_t           m_col_d;
    pos_t           m_row_q;
    pos_t           m_row_d;
    logic           busy;

    always_comb begin
        state_d = state_q;
        m_col_d = m_col_q;
        m_row_d = m_row_q;
        unique case (state_q)
            IDLE: begin
                if (launch_req) begin
                    state_d = LAUNCH;
                    m_col_d = player_col_q + HALF_W;
                    m_row_d = M_START;
                end
            end
            LAUNCH: begin
                // Hit outranks the tick: the missile dies where it is.
                if (bus.missile_hit) begin
                    state_d = IDLE;
                end else if (tick) begin
                    state_d = FLY;
                end
            end
            FLY: begin
                if (bus.missile_hit) begin
                    state_d = IDLE;
                end else if (tick) begin
                    if (m_row_q < M_STEP) begin
                        state_d = IDLE;
                    end else begin
                        m_row_d = m_row_q - M_STEP;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            m_col_q <= '0;
            m_row_q <= '0;
        end else begin
            state_q <= state_d;
            m_col_q <= m_col_d;
            m_row_q <= m_row_d;
        end
    end

    assign busy = (state_q != IDLE);

    // ------------------------------------------------------------------
    // Pixel generation
    // ------------------------------------------------------------------
    ext_t row_x;
    ext_t col_x;
    ext_t r_x;
    ext_t c_x;
    ext_t mrow_x;
    ext_t mcol_x;
    logic in_box;
    logic shape_lit;
    logic on_missile;

    always_comb begin
        row_x  = {1'b0, bus.pixel_row};
        col_x  = {1'b0, bus.pixel_column};
        mrow_x = {1'b0, m_row_q};
        mcol_x = {1'b0, m_col_q};
        r_x    = row_x - ROW_TOP;
        c_x    = col_x - pcol_x;

        in_box = (row_x >= ROW_TOP) && (row_x < ROW_END) &&
                 (col_x >= pcol_x)  && (col_x < pcol_x + SW_X);

        // Cannon silhouette: 2-row barrel, two tapering rows, solid base.
        // Only meaningful when in_box is set.
        shape_lit = 1'b1;
        if (r_x < R2_X) begin
            shape_lit = (c_x == HALF_X);
        end else if (r_x == R2_X) begin
            shape_lit = (c_x >= C2_LO) && (c_x <= C2_HI);
        end else if (r_x == R3_X) begin
            shape_lit = (c_x >= C3_LO) && (c_x <= C3_HI);
        end

        on_missile = busy && (col_x == mcol_x) &&
                     (row_x >= mrow_x) && (row_x < mrow_x + MH_X);
    end

    logic       player_active_q;
    logic [3:0] player_output_q;
    logic       missile_active_q;
    logic [3:0] missile_output_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            player_active_q  <= 1'b0;
            player_output_q  <= 4'h0;
            missile_active_q <= 1'b0;
            missile_output_q <= 4'h0;
        end else begin
            player_active_q  <= in_box;
            player_output_q  <= (in_box && shape_lit) ? PIX_VAL : 4'h0;
            missile_active_q <= on_missile;
            missile_output_q <= on_missile ? PIX_VAL : 4'h0;
        end
    end

    assign bus.player_col     = player_col_q;
    assign bus.missile_busy   = busy;
    assign bus.player_active  = player_active_q;
    assign bus.player_output  = player_output_q;
    assign bus.missile_active = missile_active_q;
    assign bus.missile_output = missile_output_q;

endmodule

// File: tb/tb_player_ctrl.sv
// -----------------------------------------------------------------------------
// tb_player_ctrl
// Directed bench for player_ctrl with MOVE_DIV=4: cannon clamping, missile
// launch/flight/top-exit, fire-while-busy, hit-on-tick, autofire relaunch
// behaviour and registered pixel outputs. Pixel expectations are queued when
// the scan position is driven and compared when the registered outputs appear.
// -----------------------------------------------------------------------------
module tb_player_ctrl;

    localparam int DIV       = 4;
    localparam int COL_MAX   = 624;
    localparam int PROW      = 450;
    localparam int M_START   = 444;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    player_ctrl_if bus ();

    player_ctrl #(
        .MOVE_DIV (DIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int edges = 0;

    // Bench model of the design state.
    int col_exp  = 312;
    int mst      = 0;      // 0 idle, 1 launch, 2 fly
    int mrow_exp = 0;
    int mcol_exp = 0;

    typedef struct {
        string      tag;
        logic       pa;
        logic [3:0] po;
        logic       ma;
        logic [3:0] mo;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        edges++;
    endtask

    // Advance to the next edge where the divider tick is applied, then update
    // the model with what that tick does.
    task automatic tick_model();
        step();
        while (edges % DIV != 0) step();
        if (bus.btn_left && !bus.btn_right)
            col_exp = (col_exp >= 4) ? col_exp - 4 : 0;
        else if (bus.btn_right && !bus.btn_left)
            col_exp = (col_exp + 4 > COL_MAX) ? COL_MAX : col_exp + 4;
        if (mst == 1) begin
            mst = 2;
        end else if (mst == 2) begin
            if (mrow_exp < 8) mst = 0;
            else mrow_exp = mrow_exp - 8;
        end
    endtask

    task automatic press_fire();
        bus.btn_fire = 1'b1;
        step();
        if (mst == 0) begin
            mst      = 1;
            mcol_exp = col_exp + 8;
            mrow_exp = M_START;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst   = 1'b0;
        edges = 0;
        col_exp = 312;
        mst     = 0;
    endtask

    function automatic exp_t expect_pix(input int row, input int col,
                                        input string tag);
        exp_t e;
        int   r;
        int   c;
        logic lit;
        r = row - PROW;
        c = col - col_exp;
        e.tag = tag;
        e.pa  = (r >= 0 && r < 10 && c >= 0 && c < 16);
        if (r == 0 || r == 1)  lit = (c == 8);
        else if (r == 2)       lit = (c >= 3 && c <= 13);
        else if (r == 3)       lit = (c >= 2 && c <= 14);
        else                   lit = 1'b1;
        e.po = (e.pa && lit) ? 4'hF : 4'h0;
        e.ma = (mst != 0) && (col == mcol_exp) &&
               (row >= mrow_exp) && (row < mrow_exp + 6);
        e.mo = e.ma ? 4'hF : 4'h0;
        return e;
    endfunction

    task automatic scan(input int row, input int col, input string tag);
        exp_t e;
        sb.push_back(expect_pix(row, col, tag));
        bus.pixel_row    = 12'(row);
        bus.pixel_column = 12'(col);
        step();
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s: observed=empty_queue expected=entry", tag);
        end else begin
            e = sb.pop_front();
            check({e.tag, "_pa"}, 16'(bus.player_active),  16'(e.pa));
            check({e.tag, "_po"}, 16'(bus.player_output),  16'(e.po));
            check({e.tag, "_ma"}, 16'(bus.missile_active), 16'(e.ma));
            check({e.tag, "_mo"}, 16'(bus.missile_output), 16'(e.mo));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1);
    end

    int scan_tab [10][2] = '{
        '{450, 320}, '{452, 313}, '{449, 320}, '{459, 312}, '{460, 312},
        '{455, 327}, '{455, 328}, '{451, 311}, '{453, 314}, '{452, 314}
    };

    initial begin
        bus.pixel_row    = '0;
        bus.pixel_column = '0;
        bus.btn_left     = 1'b0;
        bus.btn_right    = 1'b0;
        bus.btn_fire     = 1'b0;
        bus.missile_hit  = 1'b0;
        rst              = 1'b1;
        step();
        do_reset();

        // Reset state
        check("rst_col",  16'(bus.player_col),     16'd312);
        check("rst_busy", 16'(bus.missile_busy),   16'd0);
        check("rst_pa",   16'(bus.player_active),  16'd0);
        check("rst_po",   16'(bus.player_output),  16'd0);
        check("rst_ma",   16'(bus.missile_active), 16'd0);
        check("rst_mo",   16'(bus.missile_output), 16'd0);

        // Cannon pixel map around col 312
        for (int i = 0; i < 10; i++)
            scan(scan_tab[i][0], scan_tab[i][1], "cannon_pix");

        // Right to the clamp
        bus.btn_right = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick_model();
            check("right_col", 16'(bus.player_col), 16'(col_exp));
        end
        check("right_sat", 16'(bus.player_col), 16'(COL_MAX));

        // Left to zero and beyond
        bus.btn_right = 1'b0;
        bus.btn_left  = 1'b1;
        for (int i = 0; i < 170; i++) begin
            tick_model();
            check("left_col", 16'(bus.player_col), 16'(col_exp));
        end
        check("left_sat", 16'(bus.player_col), 16'd0);

        // Move off the edge, then both buttons hold position
        bus.btn_left  = 1'b0;
        bus.btn_right = 1'b1;
        for (int i = 0; i < 5; i++) tick_model();
        check("nudge_col", 16'(bus.player_col), 16'd20);
        bus.btn_left = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick_model();
            check("both_col", 16'(bus.player_col), 16'd20);
        end
        bus.btn_left  = 1'b0;
        bus.btn_right = 1'b0;

        // Full flight from col 312
        do_reset();
        tick_model();
        press_fire();
        bus.btn_fire = 1'b0;
        check("launch_busy", 16'(bus.missile_busy), 16'd1);
        scan(M_START, 320, "launch_pix");
        scan(M_START - 1, 320, "launch_above");
        tick_model();
        check("fly_busy0", 16'(bus.missile_busy), 16'd1);
        scan(M_START, 320, "fly_first");
        for (int i = 0; i < 80 && mst != 0; i++) begin
            if (i == 5) bus.btn_left = 1'b1;
            if (i == 9) bus.btn_left = 1'b0;
            tick_model();
            check("fly_busy", 16'(bus.missile_busy), 16'(mst != 0));
            check("fly_col",  16'(bus.player_col),   16'(col_exp));
            if (mst != 0) begin
                if (i == 20) bus.btn_fire = 1'b1;
                scan(mrow_exp, mcol_exp, "fly_pix");
                scan(mrow_exp + 6, mcol_exp, "fly_below");
                bus.btn_fire = 1'b0;
            end
        end
        check("top_idle", 16'(bus.missile_busy), 16'd0);

        // Hit coincident with a tick
        tick_model();
        press_fire();
        bus.btn_fire = 1'b0;
        tick_model();
        tick_model();
        step();
        step();
        step();
        bus.missile_hit = 1'b1;
        step();
        bus.missile_hit = 1'b0;
        mst = 0;
        check("hit_busy", 16'(bus.missile_busy), 16'd0);
        scan(436, mcol_exp, "hit_gone");
        scan(428, mcol_exp, "hit_nodec");

        // Fire held through a hit
        tick_model();
        press_fire();
        tick_model();
        bus.missile_hit = 1'b1;
        step();
        bus.missile_hit = 1'b0;
        mst = 0;
        check("held_hit_busy", 16'(bus.missile_busy), 16'd0);
        step();
`ifdef PLAYER_AUTOFIRE_EN
        mst      = 1;
        mcol_exp = col_exp + 8;
        mrow_exp = M_START;
        check("autofire_relaunch", 16'(bus.missile_busy), 16'd1);
        bus.btn_fire = 1'b0;
        step();
        check("autofire_stay", 16'(bus.missile_busy), 16'd1);
`else
        check("held_no_relaunch", 16'(bus.missile_busy), 16'd0);
        step();
        check("held_still_idle", 16'(bus.missile_busy), 16'd0);
        bus.btn_fire = 1'b0;
        tick_model();
        press_fire();
        bus.btn_fire = 1'b0;
        check("refire_busy", 16'(bus.missile_busy), 16'd1);
`endif

        // Reset in flight
        tick_model();
        tick_model();
        scan(mrow_exp, mcol_exp, "pre_rst_pix");
        do_reset();
        check("midrst_busy", 16'(bus.missile_busy), 16'd0);
        check("midrst_col",  16'(bus.player_col),   16'd312);
        scan(436, mcol_exp, "midrst_pix");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/player_ctrl.md
Name: player_ctrl

Overview:
- Parametrised successor to the single-sprite player block in the VGA peripheral.
- Owns the player cannon's horizontal position, driven by left/right buttons at a divided motion rate with edge clamping.
- Adds a one-shot missile with its own state machine.
- Produces registered pixel-enable and 4-bit pixel data for both the cannon and the missile, for the VGA colour mux.

Parameters:
- PIX_W, 12: width of the pixel row/column buses and position registers.
- H_RES, 640: visible columns.
- SPRITE_W, 16: cannon width in pixels (must be ≥ 8, even).
- SPRITE_H, 10: cannon height in pixels (must be ≥ 5).
- PLAYER_ROW, 450: top row of the cannon (fixed).
- STEP, 4: cannon pixels moved per motion tick.
- MOVE_DIV, 525000: clk cycles per motion tick (~60 Hz at 31.5 MHz).
- MISSILE_H, 6: missile height; the missile is 1 column wide.
- MISSILE_STEP, 8: missile rows travelled per motion tick.
- PIX_VAL, 4'hF: pixel value driven when lit.

Ports:
- clk, in, 1: pixel clock.
- rst, in, 1: synchronous reset, active-high.
- pixel_row, in, PIX_W: current scan row.
- pixel_column, in, PIX_W: current scan column.
- btn_left, in, 1: debounced; move left while held.
- btn_right, in, 1: debounced; move right while held.
- btn_fire, in, 1: debounced fire request.
- missile_hit, in, 1: one-cycle pulse from collision logic; kills the missile.
- player_col, out, PIX_W: current left column of the cannon.
- missile_busy, out, 1: high when the missile FSM is not IDLE.
- player_active, out, 1: scan position is inside the cannon bounding box.
- player_output, out, 4: cannon pixel data.
- missile_active, out, 1: scan position is on the missile.
- missile_output, out, 4: missile pixel data.

Behaviour:
- Reset (clk, rst: one clock, synchronous active-high reset):
  - player_col = (H_RES-SPRITE_W)/2, which is 312 at the defaults.
  - Missile FSM = IDLE; missile_busy = 0.
  - Tick counter = 0; fire edge register = 0.
  - All active/output ports = 0.
  - Reset asserted mid-flight aborts the missile immediately.
- Motion tick:
  - The counter counts 0..MOVE_DIV-1; tick is a 1-cycle pulse when the counter wraps.
  - MOVE_DIV=1 gives a tick every cycle.
- Cannon motion, on tick only:
  - left&&!right: col = max(0, col-STEP).
  - right&&!left: col = min(H_RES-SPRITE_W, col+STEP).
  - Both or neither held: hold.
  - Clamping is exact; there is no unsigned wrap below 0.
- Fire edge:
  - fire_rise = btn_fire & ~btn_fire_q, with btn_fire_q registered every cycle.
- Missile FSM:
  - IDLE:
    - On fire_rise, latch m_col = player_col + SPRITE_W/2 and m_row = PLAYER_ROW - MISSILE_H.
    - Then go to LAUNCH.
  - LAUNCH: on the next tick, go to FLY. The missile is drawn at its latched position.
  - FLY, on tick:
    - If m_row < MISSILE_STEP, go to IDLE (top of screen).
    - Otherwise m_row -= MISSILE_STEP.
  - Any state except IDLE: missile_hit returns to IDLE on the next edge. missile_hit has priority over the tick in the same cycle.
  - fire_rise while not IDLE is ignored, not queued.
  - The cannon still moves while the missile flies. m_col does not follow the cannon.
- Pixel outputs:
  - All four outputs are registered, with a 1-cycle latency from pixel_row/pixel_column.
  - Let r = pixel_row-PLAYER_ROW and c = pixel_column-player_col.
  - player_active = (0≤r<SPRITE_H) && (0≤c<SPRITE_W).
  - Cannon shape, evaluated inside the box:
    - r∈{0,1}: c==SPRITE_W/2.
    - r==2: 3≤c≤SPRITE_W-3.
    - r==3: 2≤c≤SPRITE_W-2.
    - r≥4: all c.
  - player_output = PIX_VAL where the shape is lit, else 0.
  - missile_active = busy && pixel_column==m_col && m_row≤pixel_row<m_row+MISSILE_H.
  - missile_output = PIX_VAL when missile_active, else 0.
- Width rule: all comparisons are done in PIX_W+1 bits so that r and c are not negative-wrapped.

Optional Feature:
- Macro: PLAYER_AUTOFIRE_EN.
- Defined:
  - In IDLE, a held btn_fire (level, not edge) launches.
  - With the button held, the missile relaunches on the first cycle after returning to IDLE.
- Undefined: only fire_rise launches.

Decomposition:
- Shared package vga_game_pkg:
  - missile_state_t enum {IDLE, LAUNCH, FLY}.
  - H_RES and V_RES constants.
  - PIX_W.
  - pix_t typedef logic [PIX_W-1:0].
- One sub-module, motion_tick:
  - Parameter DIV.
  - Ports clk, rst, tick.
  - Reused later by the alien blocks.

Test Plan (MOVE_DIV=4, defaults otherwise):
- Reset, then hold btn_right 100 ticks → player_col steps by 4 per tick from 312 and saturates at 624, never exceeding it.
- Hold btn_left → player_col reaches 0 and stays 0. Holding both buttons → no change across 10 ticks.
- Fire edge at col 312:
  - m_col = 320, m_row = 444.
  - LAUNCH, then FLY; m_row drops by 8 per tick: 436, 428, … 4.
  - Next tick → IDLE; missile_busy falls.
- Fire mid-flight is ignored (m_row unchanged). missile_hit coincident with tick → IDLE, with no decrement applied.
- Scan pixel (450,320) with col=312 → player_active=1 and player_output=F one cycle later. (452,313) → active=1, output=0. (449,320) → active=0.
- PLAYER_AUTOFIRE_EN defined with fire held → relaunch 1 cycle after IDLE is entered. Undefined → no relaunch until fire is released and pressed again.
